// File: rtl/multicycle_control.sv
// +------------------------------------------------------------------------+
// | multicycle_control                                                     |
// | Multi-cycle FSM controller sequencing fetch/decode/exec/mem/writeback  |
// | for the 16-bit CPU. Optional macro CTRL_RETIRE_CNT_EN adds a           |
// | retired-instruction counter output instr_count.                        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module multicycle_control #(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                memread,
  output logic                memwrite,
  output logic                ir_write,
  output logic                pc_write,
  output logic                jump,
  output logic                branch,
  output logic                regwrite,
  output logic                alusrc_imm,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                halted,
  output logic                illegal
`ifdef CTRL_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]    instr_count
`endif
);

  localparam logic [OPCODE_W-1:0] c_op_lw   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] c_op_sw   = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] c_op_beq  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] c_op_j    = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] c_op_addi = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] c_op_halt = OPCODE_W'(15);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic                retire_w;

  if (OPCODE_W < 4 || ALUOP_W < 2 || CNT_W < 1) begin : g_param_check
    $error("multicycle_control: parameter below minimum width");
  end

  // Full-width compare so any set bit above bit 3 makes the opcode illegal.
  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    return (op <= c_op_addi) || (op == c_op_halt);
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (!is_legal(opcode))       state_d = S_TRAP;
        else if (opcode == c_op_halt) state_d = S_HALTED;
        else                          state_d = S_EXEC;
      end
      S_EXEC: begin
        if (op_q == c_op_lw || op_q == c_op_sw)      state_d = S_MEM;
        else if (op_q == c_op_beq || op_q == c_op_j) state_d = S_FETCH;
        else                                         state_d = S_WB;
      end
      S_MEM:    if (mem_ready) state_d = (op_q == c_op_lw) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALTED: state_d = S_HALTED;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  assign retire_w = (state_q == S_WB)
                 || (state_q == S_EXEC && (op_q == c_op_beq || op_q == c_op_j))
                 || (state_q == S_MEM && mem_ready && op_q == c_op_sw);

`ifdef CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign cnt_d       = retire_w ? cnt_q + CNT_W'(1) : cnt_q;
  assign instr_count = rst_n ? cnt_q : '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
`ifdef CTRL_RETIRE_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
`ifdef CTRL_RETIRE_CNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Strobes are forced low for the whole reset cycle so an aborted access never fires.
  always_comb begin
    mem_req    = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    regwrite   = 1'b0;
    alusrc_imm = 1'b0;
    aluop      = '0;
    halted     = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          memread  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_EXEC: begin
          if (op_q == c_op_beq) begin
            aluop    = ALUOP_W'(1);
            branch   = 1'b1;
            pc_write = zero;
          end else if (op_q == c_op_j) begin
            jump     = 1'b1;
            pc_write = 1'b1;
          end else if (op_q == c_op_lw || op_q == c_op_sw || op_q == c_op_addi) begin
            alusrc_imm = 1'b1;
          end else begin
            aluop = ALUOP_W'(op_q[1:0]);
          end
        end
        S_MEM: begin
          mem_req    = 1'b1;
          alusrc_imm = 1'b1;
          memread    = (op_q == c_op_lw);
          memwrite   = (op_q == c_op_sw);
        end
        S_WB:     regwrite = 1'b1;
        S_HALTED: halted   = 1'b1;
        S_TRAP:   illegal  = 1'b1;
        default:  ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// +------------------------------------------------------------------------+
// | tb_multicycle_control                                                  |
// | Self-checking bench: per-instruction expected strobe traces built from |
// | the instruction classes, played cycle by cycle against the DUT.        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_control;

  localparam int OPCODE_W = 4;
  localparam int ALUOP_W  = 2;
  localparam int CNT_W    = 4;

  // Bit positions of the packed strobe vector compared each cycle.
  localparam logic [12:0] M_REQ  = 13'h1000;
  localparam logic [12:0] M_RD   = 13'h0800;
  localparam logic [12:0] M_WR   = 13'h0400;
  localparam logic [12:0] M_IRW  = 13'h0200;
  localparam logic [12:0] M_PCW  = 13'h0100;
  localparam logic [12:0] M_JMP  = 13'h0080;
  localparam logic [12:0] M_BR   = 13'h0040;
  localparam logic [12:0] M_REGW = 13'h0020;
  localparam logic [12:0] M_IMM  = 13'h0010;
  localparam logic [12:0] M_SUB  = 13'h0004;
  localparam logic [12:0] M_HALT = 13'h0002;
  localparam logic [12:0] M_ILL  = 13'h0001;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [OPCODE_W-1:0] opcode = '0;
  logic                zero = 1'b0;
  logic                mem_ready = 1'b0;
  logic                w_mem_req, w_memread, w_memwrite, w_ir_write, w_pc_write;
  logic                w_jump, w_branch, w_regwrite, w_alusrc_imm, w_halted, w_illegal;
  logic [ALUOP_W-1:0]  w_aluop;
  logic [CNT_W-1:0]    w_cnt;
  logic [12:0]         w_vec;

  always #5 clk = ~clk;

  multicycle_control #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (w_mem_req),
    .memread    (w_memread),
    .memwrite   (w_memwrite),
    .ir_write   (w_ir_write),
    .pc_write   (w_pc_write),
    .jump       (w_jump),
    .branch     (w_branch),
    .regwrite   (w_regwrite),
    .alusrc_imm (w_alusrc_imm),
    .aluop      (w_aluop),
    .halted     (w_halted),
    .illegal    (w_illegal)
`ifdef CTRL_RETIRE_CNT_EN
    ,
    .instr_count(w_cnt)
`endif
  );

`ifndef CTRL_RETIRE_CNT_EN
  assign w_cnt = '0;
`endif

  assign w_vec = {w_mem_req, w_memread, w_memwrite, w_ir_write, w_pc_write, w_jump,
                  w_branch, w_regwrite, w_alusrc_imm, w_aluop, w_halted, w_illegal};

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic [3:0]  opc;
    logic        z;
    logic [12:0] exp;
    logic        retire;
  } cyc_t;

  cyc_t             q[$];
  int               n_cyc;
  int               abort_at;
  bit               aborted;
  int               n_checks = 0;
  int               n_pass = 0;
  int               cyc_no = 0;
  logic [CNT_W-1:0] cnt_exp = '0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [3:0] rn();
    return 4'($urandom);
  endfunction

  task automatic push_rst();
    cyc_t c;
    c.rst_n = 1'b0; c.rdy = rb(); c.opc = rn(); c.z = rb(); c.exp = '0; c.retire = 1'b0;
    q.push_back(c);
  endtask

  // Expected cycle, or a reset cycle when the abort point is reached.
  task automatic push(input logic rdy, input logic [3:0] opc, input logic z, input logic [12:0] e);
    cyc_t c;
    if (aborted) return;
    if (n_cyc == abort_at) begin
      push_rst();
      aborted = 1'b1;
      return;
    end
    c.rst_n = 1'b1; c.rdy = rdy; c.opc = opc; c.z = z; c.exp = e; c.retire = 1'b0;
    q.push_back(c);
    n_cyc++;
  endtask

  task automatic add_instr(input logic [3:0] op, input int fw, input int mw, input logic z,
                           input int abort, input int hold);
    logic [12:0] e;
    n_cyc = 0; abort_at = abort; aborted = 1'b0;
    repeat (fw) push(1'b0, rn(), rb(), M_REQ | M_RD);
    push(1'b1, rn(), rb(), M_REQ | M_RD | M_IRW | M_PCW);
    push(rb(), op, rb(), 13'h0);
    if (op > 4'd8) begin
      repeat (hold) push(rb(), rn(), rb(), (op == 4'd15) ? M_HALT : M_ILL);
      if (!aborted) push_rst();
      return;
    end
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        push(rb(), rn(), rb(), 13'(op) << 2);
        push(rb(), rn(), rb(), M_REGW);
      end
      4'd8: begin
        push(rb(), rn(), rb(), M_IMM);
        push(rb(), rn(), rb(), M_REGW);
      end
      4'd4, 4'd5: begin
        push(rb(), rn(), rb(), M_IMM);
        e = M_REQ | M_IMM | ((op == 4'd4) ? M_RD : M_WR);
        repeat (mw) push(1'b0, rn(), rb(), e);
        push(1'b1, rn(), rb(), e);
        if (op == 4'd4) push(rb(), rn(), rb(), M_REGW);
      end
      4'd6: push(rb(), rn(), z, M_BR | M_SUB | (z ? M_PCW : 13'h0));
      default: push(rb(), rn(), rb(), M_JMP | M_PCW);
    endcase
    if (!aborted) q[$].retire = 1'b1;
  endtask

  task automatic play();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      rst_n = c.rst_n; mem_ready = c.rdy; opcode = c.opc; zero = c.z;
      @(negedge clk);
      check_eq($sformatf("strobes@%0d", cyc_no), {3'b0, w_vec}, {3'b0, c.exp});
`ifdef CTRL_RETIRE_CNT_EN
      check_eq($sformatf("instr_count@%0d", cyc_no), 16'(w_cnt),
               c.rst_n ? 16'(cnt_exp) : 16'h0);
`endif
      @(posedge clk);
      #1;
      if (!c.rst_n)       cnt_exp = '0;
      else if (c.retire)  cnt_exp = cnt_exp + 1'b1;
      cyc_no++;
    end
  endtask

  initial begin
    int r;
    logic [3:0] op;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    push_rst();
    add_instr(4'd0, 0, 0, 1'b0, -1, 0);
    add_instr(4'd4, 0, 3, 1'b0, -1, 0);
    add_instr(4'd6, 0, 0, 1'b1, -1, 0);
    add_instr(4'd6, 1, 0, 1'b0, -1, 0);
    add_instr(4'd9, 0, 0, 1'b0, -1, 10);
    add_instr(4'd15, 0, 0, 1'b0, -1, 10);
    // SW with a long memory wait, reset lands on the third MEM cycle.
    add_instr(4'd5, 0, 4, 1'b0, 5, 0);
`ifdef CTRL_RETIRE_CNT_EN
    repeat (17) add_instr(4'd0, 0, 0, 1'b0, -1, 0);
    add_instr(4'd15, 0, 0, 1'b0, -1, 3);
`endif
    add_instr(4'd0, 1, 0, 1'b0, -1, 0);
    play();

    repeat (150) begin
      r = $urandom_range(0, 19);
      if (r < 18)       op = 4'(r % 9);
      else if (r == 18) op = 4'd15;
      else              op = 4'($urandom_range(9, 14));
      add_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), rb(),
                ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1,
                $urandom_range(1, 4));
    end
    play();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
